// File: rtl/execute_and_store_back_pkg.sv
// Shared definitions for the execute/writeback stage: widths, opcodes,
// FSM state encoding and processor-status-word bit positions.
package exec_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 8;
    localparam int REG_W  = 4;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_HALT  = 4'd1;
    localparam logic [3:0] OP_ADD   = 4'd2;
    localparam logic [3:0] OP_SUB   = 4'd3;
    localparam logic [3:0] OP_MUL   = 4'd4;
    localparam logic [3:0] OP_AND   = 4'd5;
    localparam logic [3:0] OP_OR    = 4'd6;
    localparam logic [3:0] OP_XOR   = 4'd7;
    localparam logic [3:0] OP_NAND  = 4'd8;
    localparam logic [3:0] OP_NOT   = 4'd9;
    localparam logic [3:0] OP_SHL   = 4'd10;
    localparam logic [3:0] OP_SHR   = 4'd11;
    localparam logic [3:0] OP_MOV   = 4'd12;
    localparam logic [3:0] OP_CMP   = 4'd13;
    localparam logic [3:0] OP_LOAD  = 4'd14;
    localparam logic [3:0] OP_STORE = 4'd15;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_EXEC  = 3'd1,
        ST_WB    = 3'd2,
        ST_MEMRD = 3'd3,
        ST_MEMWR = 3'd4,
        ST_HALT  = 3'd5
    } state_t;

    localparam int PSW_Z = 0;
    localparam int PSW_N = 1;
    localparam int PSW_C = 2;
    localparam int PSW_V = 3;

endpackage

// File: rtl/execute_and_store_back_if.sv
// Bundle of the instruction input, register-file writeback and memory
// handshake signals of the execute/writeback stage.
// slave  : the stage itself.
// master : the surrounding pipeline / register file / memory.
interface execute_and_store_back_if;
    import exec_pkg::*;

    logic [3:0]        opcode;
    logic [REG_W-1:0]  destReg;
    logic [DATA_W-1:0] srcVal1;
    logic [DATA_W-1:0] srcVal2;
    logic [ADDR_W-1:0] memAddr;
    logic              used1;
    logic              used2;

    logic [REG_W-1:0]  destRegStore;
    logic [DATA_W-1:0] destVal;
    logic              storeNow;
    logic              storeDone;

    logic [ADDR_W-1:0] memAddrLoadStore;
    logic [DATA_W-1:0] memValueStore;
    logic [DATA_W-1:0] memValueLoad;
    logic              valueReady;
    logic              readReq;

    logic [DATA_W-1:0] ProcessorStatusWord;
    logic              powerdown;

    modport slave (
        input  opcode, destReg, srcVal1, srcVal2, memAddr, used1, used2,
        input  storeDone, memValueLoad, valueReady,
        output destRegStore, destVal, storeNow,
        output memAddrLoadStore, memValueStore, readReq,
        output ProcessorStatusWord, powerdown
    );

    modport master (
        output opcode, destReg, srcVal1, srcVal2, memAddr, used1, used2,
        output storeDone, memValueLoad, valueReady,
        input  destRegStore, destVal, storeNow,
        input  memAddrLoadStore, memValueStore, readReq,
        input  ProcessorStatusWord, powerdown
    );
endinterface

// File: rtl/execute_and_store_back_alu.sv
// Combinational ALU of the execute stage: result plus Z/N/C/V flags.
// Flags are only meaningful for opcodes ADD..CMP; the caller decides
// when to commit them.
module exec_alu
    import exec_pkg::*;
(
    input  logic [3:0]        opcode_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] result_o,
    output logic [3:0]        flags_o
);

    logic [DATA_W:0] sum_ext;
    logic [DATA_W:0] diff_ext;
    logic [DATA_W:0] shl_ext;
    logic [DATA_W:0] shr_ext;
    logic            carry;
    logic            ovf;

    // Extended-width intermediates expose carry/borrow and the shifted-out bit
    assign sum_ext  = {1'b0, a_i} + {1'b0, b_i};
    assign diff_ext = {1'b0, a_i} - {1'b0, b_i};
    assign shl_ext  = {1'b0, a_i} << b_i[3:0];
    assign shr_ext  = {a_i, 1'b0} >> b_i[3:0];

    // Result and carry/overflow selection by opcode
    always_comb begin
        result_o = '0;
        carry    = 1'b0;
        ovf      = 1'b0;
        case (opcode_i)
            OP_ADD: begin
                result_o = sum_ext[DATA_W-1:0];
                carry    = sum_ext[DATA_W];
                ovf      = (a_i[DATA_W-1] == b_i[DATA_W-1]) &&
                           (sum_ext[DATA_W-1] != a_i[DATA_W-1]);
            end
            OP_SUB, OP_CMP: begin
                result_o = diff_ext[DATA_W-1:0];
                carry    = diff_ext[DATA_W];
                ovf      = (a_i[DATA_W-1] != b_i[DATA_W-1]) &&
                           (diff_ext[DATA_W-1] != a_i[DATA_W-1]);
            end
            OP_MUL:  result_o = a_i * b_i;
            OP_AND:  result_o = a_i & b_i;
            OP_OR:   result_o = a_i | b_i;
            OP_XOR:  result_o = a_i ^ b_i;
            OP_NAND: result_o = ~(a_i & b_i);
            OP_NOT:  result_o = ~a_i;
            OP_SHL: begin
                result_o = shl_ext[DATA_W-1:0];
                carry    = shl_ext[DATA_W];
            end
            OP_SHR: begin
                result_o = shr_ext[DATA_W:1];
                carry    = shr_ext[0];
            end
            OP_MOV:  result_o = a_i;
            default: result_o = '0;
        endcase
    end

    // Pack flags into their status-word bit positions
    always_comb begin
        flags_o        = '0;
        flags_o[PSW_Z] = (result_o == '0);
        flags_o[PSW_N] = result_o[DATA_W-1];
        flags_o[PSW_C] = carry;
        flags_o[PSW_V] = ovf;
    end

endmodule

// File: rtl/execute_and_store_back.sv
// Execute/writeback stage of the 3-stage 16-bit pipeline.
// Accepts one decoded instruction in IDLE, executes it, and either writes
// the result back to the register file (storeNow/storeDone) or performs a
// memory load/store (readReq/valueReady). Holds the status word, the
// forward register and the sticky halt state.
// Optional feature: define FORWARD_EN to let used1/used2 substitute the
// forward register for the corresponding operand when sampling.
module execute_and_store_back
    import exec_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    execute_and_store_back_if.slave    bus
);

    state_t            state_q, state_d;

    // Latched instruction
    logic [3:0]        op_q, op_d;
    logic [REG_W-1:0]  dest_q, dest_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    // Registered outputs and architectural state
    logic [REG_W-1:0]  dest_reg_store_q, dest_reg_store_d;
    logic [DATA_W-1:0] dest_val_q, dest_val_d;
    logic              store_now_q, store_now_d;
    logic              read_req_q, read_req_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_value_q, mem_value_d;
    logic [3:0]        psw_q, psw_d;
    logic              powerdown_q, powerdown_d;
    logic [DATA_W-1:0] fwd_q, fwd_d;

    logic [DATA_W-1:0] op1_sel;
    logic [DATA_W-1:0] op2_sel;
    logic [DATA_W-1:0] alu_result;
    logic [3:0]        alu_flags;

`ifdef FORWARD_EN
    // Forwarding: substitute the last computed/loaded result for flagged operands
    always_comb begin
        op1_sel = bus.used1 ? fwd_q : bus.srcVal1;
        op2_sel = bus.used2 ? fwd_q : bus.srcVal2;
    end
`else
    logic unused_fwd_flags;
    assign unused_fwd_flags = bus.used1 ^ bus.used2;

    // Operands are taken exactly as presented
    always_comb begin
        op1_sel = bus.srcVal1;
        op2_sel = bus.srcVal2;
    end
`endif

    exec_alu u_alu (
        .opcode_i (op_q),
        .a_i      (a_q),
        .b_i      (b_q),
        .result_o (alu_result),
        .flags_o  (alu_flags)
    );

    // State and output registers; reset aborts any handshake in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            op_q             <= OP_NOP;
            dest_q           <= '0;
            a_q              <= '0;
            b_q              <= '0;
            addr_q           <= '0;
            dest_reg_store_q <= '0;
            dest_val_q       <= '0;
            store_now_q      <= 1'b0;
            read_req_q       <= 1'b0;
            mem_addr_q       <= '0;
            mem_value_q      <= '0;
            psw_q            <= '0;
            powerdown_q      <= 1'b0;
            fwd_q            <= '0;
        end else begin
            state_q          <= state_d;
            op_q             <= op_d;
            dest_q           <= dest_d;
            a_q              <= a_d;
            b_q              <= b_d;
            addr_q           <= addr_d;
            dest_reg_store_q <= dest_reg_store_d;
            dest_val_q       <= dest_val_d;
            store_now_q      <= store_now_d;
            read_req_q       <= read_req_d;
            mem_addr_q       <= mem_addr_d;
            mem_value_q      <= mem_value_d;
            psw_q            <= psw_d;
            powerdown_q      <= powerdown_d;
            fwd_q            <= fwd_d;
        end
    end

    // Next-state and next-output logic of the instruction FSM
    always_comb begin
        state_d          = state_q;
        op_d             = op_q;
        dest_d           = dest_q;
        a_d              = a_q;
        b_d              = b_q;
        addr_d           = addr_q;
        dest_reg_store_d = dest_reg_store_q;
        dest_val_d       = dest_val_q;
        store_now_d      = store_now_q;
        read_req_d       = read_req_q;
        mem_addr_d       = mem_addr_q;
        mem_value_d      = mem_value_q;
        psw_d            = psw_q;
        powerdown_d      = powerdown_q;
        fwd_d            = fwd_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.opcode == OP_HALT) begin
                    powerdown_d = 1'b1;
                    state_d     = ST_HALT;
                end else if (bus.opcode != OP_NOP) begin
                    op_d    = bus.opcode;
                    dest_d  = bus.destReg;
                    a_d     = op1_sel;
                    b_d     = op2_sel;
                    addr_d  = bus.memAddr;
                    state_d = ST_EXEC;
                end
            end

            ST_EXEC: begin
                if (op_q == OP_LOAD) begin
                    dest_reg_store_d = dest_q;
                    mem_addr_d       = addr_q;
                    read_req_d       = 1'b1;
                    store_now_d      = 1'b0;
                    state_d          = ST_MEMRD;
                end else if (op_q == OP_STORE) begin
                    mem_addr_d  = addr_q;
                    mem_value_d = a_q;
                    read_req_d  = 1'b1;
                    store_now_d = 1'b1;
                    state_d     = ST_MEMWR;
                end else begin
                    psw_d = alu_flags;
                    fwd_d = alu_result;
                    if (op_q == OP_CMP) begin
                        state_d = ST_IDLE;
                    end else begin
                        dest_reg_store_d = dest_q;
                        dest_val_d       = alu_result;
                        store_now_d      = 1'b1;
                        state_d          = ST_WB;
                    end
                end
            end

            ST_WB: begin
                if (bus.storeDone) begin
                    store_now_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end

            ST_MEMRD: begin
                if (bus.valueReady) begin
                    dest_val_d  = bus.memValueLoad;
                    fwd_d       = bus.memValueLoad;
                    read_req_d  = 1'b0;
                    store_now_d = 1'b1;
                    state_d     = ST_WB;
                end
            end

            ST_MEMWR: begin
                if (bus.valueReady) begin
                    read_req_d  = 1'b0;
                    store_now_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end

            ST_HALT: begin
                powerdown_d = 1'b1;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.destRegStore        = dest_reg_store_q;
    assign bus.destVal             = dest_val_q;
    assign bus.storeNow            = store_now_q;
    assign bus.readReq             = read_req_q;
    assign bus.memAddrLoadStore    = mem_addr_q;
    assign bus.memValueStore       = mem_value_q;
    assign bus.ProcessorStatusWord = {{(DATA_W-4){1'b0}}, psw_q};
    assign bus.powerdown           = powerdown_q;

endmodule

// File: tb/tb_execute_and_store_back.sv
// Directed bench for the execute/writeback stage. Inputs change and outputs
// are sampled on the falling edge; the design acts on the rising edge.
module tb_execute_and_store_back;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    logic [15:0] fwd_exp;

    execute_and_store_back_if bus ();

    execute_and_store_back dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present an instruction for one rising edge, then return to NOP.
    // Returns at the falling edge after the sampling edge.
    task automatic send(input logic [3:0] op, input logic [3:0] dest,
                        input logic [15:0] a, input logic [15:0] b,
                        input logic [7:0] addr, input logic u1, input logic u2);
        bus.opcode  = op;
        bus.destReg = dest;
        bus.srcVal1 = a;
        bus.srcVal2 = b;
        bus.memAddr = addr;
        bus.used1   = u1;
        bus.used2   = u2;
        @(posedge clk);
        @(negedge clk);
        bus.opcode = 4'd0;
        bus.used1  = 1'b0;
        bus.used2  = 1'b0;
        $display("issued op=%0d dest=%0d a=%0h b=%0h addr=%0h", op, dest, a, b, addr);
    endtask

    // Called right after send(): follows EXEC -> WB -> storeDone -> IDLE.
    task automatic alu_wb(input string tag, input logic [3:0] dest,
                          input logic [15:0] val, input logic [15:0] psw);
        check({tag, "_exec_sn"}, bus.storeNow, 1'b0);
        @(negedge clk);
        check({tag, "_sn"},   bus.storeNow, 1'b1);
        check({tag, "_dest"}, bus.destRegStore, dest);
        check({tag, "_val"},  bus.destVal, val);
        check({tag, "_psw"},  bus.ProcessorStatusWord, psw);
        @(negedge clk);
        check({tag, "_hold_sn"},  bus.storeNow, 1'b1);
        check({tag, "_hold_val"}, bus.destVal, val);
        bus.storeDone = 1'b1;
        @(negedge clk);
        bus.storeDone = 1'b0;
        check({tag, "_done_sn"}, bus.storeNow, 1'b0);
        $display("wb %s dest=%0d val=%0h psw=%0h", tag, bus.destRegStore, bus.destVal, bus.ProcessorStatusWord);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        bus.opcode = 4'd0; bus.destReg = 4'd0; bus.srcVal1 = 16'd0; bus.srcVal2 = 16'd0;
        bus.memAddr = 8'd0; bus.used1 = 1'b0; bus.used2 = 1'b0;
        bus.storeDone = 1'b0; bus.memValueLoad = 16'd0; bus.valueReady = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_sn",   bus.storeNow, 1'b0);
        check("rst_rr",   bus.readReq, 1'b0);
        check("rst_psw",  bus.ProcessorStatusWord, 16'h0000);
        check("rst_pd",   bus.powerdown, 1'b0);
        check("rst_val",  bus.destVal, 16'h0000);
        rst = 1'b0;
        @(negedge clk);

        // Arithmetic and logic writebacks
        send(4'd2, 4'd12, 16'd24, 16'd30, 8'd0, 1'b0, 1'b0);
        alu_wb("add", 4'd12, 16'd54, 16'h0000);
        send(4'd3, 4'd13, 16'd25, 16'd9, 8'd0, 1'b0, 1'b0);
        alu_wb("sub", 4'd13, 16'd16, 16'h0000);

        // CMP: flags only, no writeback request
        send(4'd13, 4'd1, 16'd5, 16'd5, 8'd0, 1'b0, 1'b0);
        @(negedge clk);
        check("cmp_sn",  bus.storeNow, 1'b0);
        check("cmp_psw", bus.ProcessorStatusWord, 16'h0001);
        @(negedge clk);
        check("cmp_sn2", bus.storeNow, 1'b0);
        check("cmp_rr",  bus.readReq, 1'b0);
        $display("cmp psw=%0h", bus.ProcessorStatusWord);

        send(4'd5, 4'd2, 16'd24, 16'd5, 8'd0, 1'b0, 1'b0);
        alu_wb("and", 4'd2, 16'd0, 16'h0001);
        send(4'd7, 4'd3, 16'd56, 16'd32, 8'd0, 1'b0, 1'b0);
        alu_wb("xor", 4'd3, 16'd24, 16'h0000);
        send(4'd9, 4'd14, 16'd11, 16'd0, 8'd0, 1'b0, 1'b0);
        alu_wb("not", 4'd14, 16'hFFF4, 16'h0002);

        // Flag boundaries: carry+zero, signed overflow, shifted-out bit
        send(4'd2, 4'd4, 16'hFFFF, 16'h0001, 8'd0, 1'b0, 1'b0);
        alu_wb("add_c", 4'd4, 16'h0000, 16'h0005);
        send(4'd3, 4'd5, 16'h8000, 16'h0001, 8'd0, 1'b0, 1'b0);
        alu_wb("sub_v", 4'd5, 16'h7FFF, 16'h0008);
        send(4'd10, 4'd6, 16'h8001, 16'h0001, 8'd0, 1'b0, 1'b0);
        alu_wb("shl", 4'd6, 16'h0002, 16'h0004);

        // STORE: readReq and storeNow together, held until valueReady
        send(4'd15, 4'd0, 16'd45, 16'd0, 8'd180, 1'b0, 1'b0);
        @(negedge clk);
        check("st_rr",   bus.readReq, 1'b1);
        check("st_sn",   bus.storeNow, 1'b1);
        check("st_addr", bus.memAddrLoadStore, 8'd180);
        check("st_data", bus.memValueStore, 16'd45);
        @(negedge clk);
        check("st_hold_rr", bus.readReq, 1'b1);
        bus.valueReady = 1'b1;
        @(negedge clk);
        bus.valueReady = 1'b0;
        check("st_done_rr", bus.readReq, 1'b0);
        check("st_done_sn", bus.storeNow, 1'b0);
        check("st_psw",     bus.ProcessorStatusWord, 16'h0004);
        $display("store addr=%0d data=%0d", bus.memAddrLoadStore, bus.memValueStore);

        // LOAD: read handshake, then register writeback
        send(4'd14, 4'd3, 16'd0, 16'd0, 8'd180, 1'b0, 1'b0);
        @(negedge clk);
        check("ld_rr",   bus.readReq, 1'b1);
        check("ld_sn",   bus.storeNow, 1'b0);
        check("ld_addr", bus.memAddrLoadStore, 8'd180);
        bus.memValueLoad = 16'd45;
        bus.valueReady   = 1'b1;
        @(negedge clk);
        bus.valueReady = 1'b0;
        check("ld_rr_drop", bus.readReq, 1'b0);
        check("ld_sn",      bus.storeNow, 1'b1);
        check("ld_dest",    bus.destRegStore, 4'd3);
        check("ld_val",     bus.destVal, 16'd45);
        bus.storeDone = 1'b1;
        @(negedge clk);
        bus.storeDone = 1'b0;
        check("ld_done_sn", bus.storeNow, 1'b0);
        $display("load val=%0d", bus.destVal);

        // Forwarding
        send(4'd2, 4'd12, 16'd24, 16'd30, 8'd0, 1'b0, 1'b0);
        alu_wb("add2", 4'd12, 16'd54, 16'h0000);
`ifdef FORWARD_EN
        fwd_exp = 16'd108;
`else
        fwd_exp = 16'd29;
`endif
        send(4'd2, 4'd7, 16'd15, 16'd14, 8'd0, 1'b1, 1'b1);
        alu_wb("fwd", 4'd7, fwd_exp, 16'h0000);

        // Reset during WB aborts the handshake immediately
        send(4'd2, 4'd8, 16'hFFFF, 16'h0001, 8'd0, 1'b0, 1'b0);
        @(negedge clk);
        check("rwb_sn",  bus.storeNow, 1'b1);
        check("rwb_psw", bus.ProcessorStatusWord, 16'h0005);
        #2 rst = 1'b1;
        #1;
        check("rwb_sn_rst",  bus.storeNow, 1'b0);
        check("rwb_psw_rst", bus.ProcessorStatusWord, 16'h0000);
        check("rwb_dst_rst", bus.destRegStore, 4'd0);
        $display("reset mid-wb sn=%0b psw=%0h", bus.storeNow, bus.ProcessorStatusWord);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // HALT is sticky; later instructions ignored
        send(4'd1, 4'd0, 16'd0, 16'd0, 8'd0, 1'b0, 1'b0);
        check("halt_pd", bus.powerdown, 1'b1);
        send(4'd2, 4'd9, 16'd1, 16'd2, 8'd0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("halt_sn", bus.storeNow, 1'b0);
        check("halt_rr", bus.readReq, 1'b0);
        check("halt_pd2", bus.powerdown, 1'b1);
        check("halt_val", bus.destVal, 16'h0000);
        $display("halt pd=%0b", bus.powerdown);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
